// File: rtl/wb_arbiter_if.sv
// Bus bundle between the ALU/LSU/decode producers and the writeback arbiter.
// slave is the arbiter side; master is the producer/consumer side.
interface wb_arbiter_if;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [31:0] busy;
    logic        rg_write_en;
    logic [4:0]  rg_des_addr;
    logic [31:0] rg_des_data;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  iss_valid, iss_rd,
        output alu_ready, lsu_ready, busy,
        output rg_write_en, rg_des_addr, rg_des_data
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output iss_valid, iss_rd,
        input  alu_ready, lsu_ready, busy,
        input  rg_write_en, rg_des_addr, rg_des_data
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and LSU results onto the registered write port,
// bounds LSU starvation, and tracks destinations of outstanding loads.
module wb_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input logic       clk,
    input logic       rst,
    wb_arbiter_if.slave bus
);
    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

    logic [3:0]  wait_cnt;
    logic        src_lsu;
    logic        starve;
    logic        alu_ready;
    logic        lsu_ready;
    logic        alu_acc;
    logic        lsu_acc;
    logic [31:0] busy;
    logic [31:0] busy_nxt;
    logic        rg_write_en;
    logic [4:0]  rg_des_addr;
    logic [31:0] rg_des_data;

    always_comb begin
        starve = (wait_cnt == WAIT_LIM) && bus.lsu_valid;
        if (rst) begin
            alu_ready = 1'b0;
            lsu_ready = 1'b0;
        end else if (starve) begin
            alu_ready = 1'b0;
            lsu_ready = 1'b1;
        end else begin
            alu_ready = 1'b1;
            lsu_ready = !bus.alu_valid;
        end
        alu_acc = bus.alu_valid && alu_ready;
        lsu_acc = bus.lsu_valid && lsu_ready;
    end

    // Only a load result leaving the write port retires its busy bit; a new
    // issue to the same register on that edge keeps it set.
    always_comb begin
        busy_nxt = busy;
        for (int n = 1; n < 32; n++) begin
            if (bus.iss_valid && bus.iss_rd == 5'(n))
                busy_nxt[n] = 1'b1;
            else if (rg_write_en && src_lsu && rg_des_addr == 5'(n))
                busy_nxt[n] = 1'b0;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt    <= 4'd0;
            src_lsu     <= 1'b0;
            rg_write_en <= 1'b0;
            rg_des_addr <= 5'd0;
            rg_des_data <= 32'd0;
            busy        <= 32'd0;
        end else begin
            if (!bus.lsu_valid || lsu_acc)
                wait_cnt <= 4'd0;
            else if (wait_cnt < WAIT_LIM)
                wait_cnt <= wait_cnt + 4'd1;

            if (lsu_acc) begin
                rg_write_en <= (bus.lsu_rd != 5'd0);
                rg_des_addr <= bus.lsu_rd;
                rg_des_data <= bus.lsu_data;
                src_lsu     <= 1'b1;
            end else if (alu_acc) begin
                rg_write_en <= (bus.alu_rd != 5'd0);
                rg_des_addr <= bus.alu_rd;
                rg_des_data <= bus.alu_data;
                src_lsu     <= 1'b0;
            end else begin
                rg_write_en <= 1'b0;
                src_lsu     <= 1'b0;
            end

            busy <= busy_nxt;
        end
    end

    assign bus.alu_ready   = alu_ready;
    assign bus.lsu_ready   = lsu_ready;
    assign bus.busy        = busy;
    assign bus.rg_write_en = rg_write_en;
    assign bus.rg_des_addr = rg_des_addr;
    assign bus.rg_des_data = rg_des_data;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: expected register writes are queued as stimulus is
// issued and a negedge monitor checks each write-port event against the queue.
module tb_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t exp_q[$];

    wb_arbiter_if bus();

    wb_arbiter #(.MAX_WAIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Write-port monitor: every committed write must match the queue head,
    // including the cycle it was predicted to appear in.
    always @(negedge clk) begin
        if (bus.rg_write_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write actual addr=%0d data=%h cycle=%0d required none",
                         bus.rg_des_addr, bus.rg_des_data, cyc);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (bus.rg_des_addr !== e.addr || bus.rg_des_data !== e.data || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL write_port actual addr=%0d data=%h cycle=%0d required addr=%0d data=%h cycle=%0d",
                             bus.rg_des_addr, bus.rg_des_data, cyc, e.addr, e.data, e.cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                         input logic iv, input logic [4:0] ird);
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_data  = adat;
        bus.lsu_valid = lv;
        bus.lsu_rd    = lrd;
        bus.lsu_data  = ldat;
        bus.iss_valid = iv;
        bus.iss_rd    = ird;
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
        wr_t e;
        e.addr = rd;
        e.data = data;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with both sources valid and an issue pending
        rst = 1'b1;
        drive(1, 5'd3, 32'h1111_1111, 1, 5'd4, 32'h2222_2222, 1, 5'd6);
        chk("rst_alu_ready", 32'(bus.alu_ready), 32'd0);
        chk("rst_lsu_ready", 32'(bus.lsu_ready), 32'd0);
        step();
        chk("rst_we", 32'(bus.rg_write_en), 32'd0);
        chk("rst_busy", bus.busy, 32'd0);
        chk("rst_addr", 32'(bus.rg_des_addr), 32'd0);
        step();
        rst = 1'b0;
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0);
        step();

        // ALU only
        drive(1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 32'd0, 0, 5'd0);
        chk("alu_ready", 32'(bus.alu_ready), 32'd1);
        expect_wr(5'd5, 32'hDEAD_BEEF);
        step();
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0);
        step();
        chk("alu_we_drop", 32'(bus.rg_write_en), 32'd0);

        // Starvation: ALU always valid, LSU rd=7 forced through after 4 losses
        for (int i = 0; i < 4; i++) begin
            drive(1, 5'(10 + i), 32'h100 + 32'(i), 1, 5'd7, 32'h77, 0, 5'd0);
            chk("starve_lsu_wait", 32'(bus.lsu_ready), 32'd0);
            chk("starve_alu_win", 32'(bus.alu_ready), 32'd1);
            expect_wr(5'(10 + i), 32'h100 + 32'(i));
            step();
        end
        drive(1, 5'd14, 32'h104, 1, 5'd7, 32'h77, 0, 5'd0);
        chk("starve_lsu_forced", 32'(bus.lsu_ready), 32'd1);
        chk("starve_alu_held", 32'(bus.alu_ready), 32'd0);
        expect_wr(5'd7, 32'h77);
        step();
        // wait count must restart after the forced transfer
        drive(1, 5'd14, 32'h104, 1, 5'd8, 32'h88, 0, 5'd0);
        chk("wait_cleared", 32'(bus.lsu_ready), 32'd0);
        expect_wr(5'd14, 32'h104);
        step();
        drive(0, 5'd0, 32'd0, 1, 5'd8, 32'h88, 0, 5'd0);
        chk("lsu_alone_ready", 32'(bus.lsu_ready), 32'd1);
        expect_wr(5'd8, 32'h88);
        step();
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0);
        step();

        // Scoreboard set and LSU-driven clear of x9
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd9);
        step();
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0);
        chk("busy9_set", bus.busy, 32'h0000_0200);
        step();
        step();
        chk("busy9_hold", bus.busy, 32'h0000_0200);
        drive(0, 5'd0, 32'd0, 1, 5'd9, 32'h99, 0, 5'd0);
        expect_wr(5'd9, 32'h99);
        step();
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0);
        chk("busy9_during_write", bus.busy, 32'h0000_0200);
        step();
        chk("busy9_cleared", bus.busy, 32'd0);

        // ALU write to a busy register must not clear it
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd9);
        step();
        drive(1, 5'd9, 32'hA1A1, 0, 5'd0, 32'd0, 0, 5'd0);
        expect_wr(5'd9, 32'hA1A1);
        step();
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0);
        step();
        chk("alu_no_clear", bus.busy, 32'h0000_0200);

        // LSU write for x9 and a fresh issue to x9 hit the same edge
        drive(0, 5'd0, 32'd0, 1, 5'd9, 32'h9A, 0, 5'd0);
        expect_wr(5'd9, 32'h9A);
        step();
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd9);
        step();
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0);
        chk("busy9_set_wins", bus.busy, 32'h0000_0200);
        drive(0, 5'd0, 32'd0, 1, 5'd9, 32'h9B, 0, 5'd0);
        expect_wr(5'd9, 32'h9B);
        step();
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0);
        step();
        chk("busy9_final_clear", bus.busy, 32'd0);

        // x0 handling
        drive(1, 5'd0, 32'h1234, 0, 5'd0, 32'd0, 0, 5'd0);
        chk("x0_alu_ready", 32'(bus.alu_ready), 32'd1);
        step();
        drive(0, 5'd0, 32'd0, 1, 5'd0, 32'h5678, 0, 5'd0);
        chk("x0_lsu_ready", 32'(bus.lsu_ready), 32'd1);
        chk("x0_alu_we", 32'(bus.rg_write_en), 32'd0);
        step();
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd0);
        chk("x0_lsu_we", 32'(bus.rg_write_en), 32'd0);
        step();
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0);
        chk("x0_issue_busy", bus.busy, 32'd0);

        // Reset mid-operation drops pending bits and the in-flight write
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd12);
        step();
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0);
        chk("busy12_set", bus.busy, 32'h0000_1000);
        rst = 1'b1;
        drive(1, 5'd3, 32'hCAFE, 0, 5'd0, 32'd0, 0, 5'd0);
        chk("midrst_alu_ready", 32'(bus.alu_ready), 32'd0);
        step();
        rst = 1'b0;
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0);
        chk("midrst_we", 32'(bus.rg_write_en), 32'd0);
        chk("midrst_busy", bus.busy, 32'd0);

        // Back-to-back ALU writes, one per cycle
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'(20 + i), 32'hB000 + 32'(i), 0, 5'd0, 32'd0, 0, 5'd0);
            expect_wr(5'(20 + i), 32'hB000 + 32'(i));
            step();
        end
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0);
        step();
        step();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
